uart_cfg_regbank: RTL and testbench

//  Multi-channel successor of the single-UART config regfile: N_CH channels, each with CTRL, BAUD, STATUS, IRQ_EN.

---
 rtl/uart_cfg_pkg.sv | 46 ++++
 rtl/uart_cfg_regbank_if.sv | 30 +++
 rtl/uart_cfg_channel.sv | 83 ++++++++
 rtl/uart_cfg_regbank.sv | 129 ++++++++++++
 tb/tb_uart_cfg_regbank.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cfg_pkg.sv
// Shared register map, bit positions and per-channel register record for the UART config bank.
package uart_cfg_pkg;

  localparam int unsigned BAUD_RST_DEFAULT = 9600;

  // Register offsets within a channel (addr[1:0])
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_BAUD   = 2'd1,
    REG_STATUS = 2'd2,
    REG_IRQ_EN = 2'd3
  } reg_e;

  // CTRL bit positions
  localparam int unsigned CTRL_EN = 0;

  // STATUS bit positions
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_ERR     = 1;
  localparam int unsigned ST_PEND    = 2;
  localparam int unsigned ST_CFG_ERR = 3;

  // IRQ_EN occupies bits [3:1]; stored as irq_en[2:0], so STATUS bit k maps to irq_en[k-1]
  localparam int unsigned IEN_LSB = 1;

  // Stored state of one channel (BAUD shadow/active are width-dependent and kept separately)
  typedef struct packed {
    logic [3:0] ctrl;
    logic [2:0] irq_en;
    logic       pending;
    logic       err;
    logic       cfg_err;
  } ch_regs_t;

  // STATUS read view: live busy plus stored flags
  function automatic logic [3:0] status_bits(ch_regs_t r, logic busy);
    logic [3:0] s;
    s             = '0;
    s[ST_BUSY]    = busy;
    s[ST_ERR]     = r.err;
    s[ST_PEND]    = r.pending;
    s[ST_CFG_ERR] = r.cfg_err;
    return s;
  endfunction

endpackage

// File: rtl/uart_cfg_regbank_if.sv
// Config bus: one write port and two independent read ports.
interface uart_cfg_regbank_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N_CH       = 3
);
  localparam int unsigned AW = $clog2(N_CH) + 2;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  rd_en_a;
  logic [AW-1:0]         rd_addr_a;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic                  rd_valid_a;
  logic                  rd_en_b;
  logic [AW-1:0]         rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  rd_valid_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_err, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_err, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b
  );
endinterface

// File: rtl/uart_cfg_channel.sv
// One UART channel: CTRL/IRQ_EN storage, shadowed BAUD with commit, sticky W1C errors, IRQ.
module uart_cfg_channel
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BAUD_RST   = BAUD_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  reg_e                  wr_reg_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  busy_i,
  input  logic                  error_i,
  input  logic                  update_ok_i,
  output ch_regs_t              regs_o,
  output logic [DATA_WIDTH-1:0] rate_o,
  output logic                  irq_o
);

  ch_regs_t              regs_q, regs_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic                  irq_q, irq_d;
  logic                  clr_err, clr_cfg_err, baud_reject;

  assign clr_err     = wr_en_i && (wr_reg_i == REG_STATUS) && wr_data_i[ST_ERR];
  assign clr_cfg_err = wr_en_i && (wr_reg_i == REG_STATUS) && wr_data_i[ST_CFG_ERR];
  assign baud_reject = wr_en_i && (wr_reg_i == REG_BAUD) && busy_i;

  // Next state: commit first so a same-cycle BAUD write re-arms pending with the new shadow
  always_comb begin
    regs_d   = regs_q;
    shadow_d = shadow_q;
    active_d = active_q;

    if (update_ok_i && regs_q.pending) begin
      active_d       = shadow_q;
      regs_d.pending = 1'b0;
    end

    if (wr_en_i) begin
      case (wr_reg_i)
        REG_CTRL:   regs_d.ctrl = wr_data_i[3:0];
        REG_BAUD: begin
          if (!busy_i) begin
            shadow_d       = wr_data_i;
            regs_d.pending = 1'b1;
          end
        end
        REG_IRQ_EN: regs_d.irq_en = wr_data_i[3:1];
        default: ;
      endcase
    end

    // Set beats clear on the sticky flags
    regs_d.err     = error_i | (regs_q.err & ~clr_err);
    regs_d.cfg_err = baud_reject | (regs_q.cfg_err & ~clr_cfg_err);

    irq_d = (regs_q.err     & regs_q.irq_en[ST_ERR - IEN_LSB]) |
            (regs_q.cfg_err & regs_q.irq_en[ST_CFG_ERR - IEN_LSB]);
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      shadow_q <= DATA_WIDTH'(BAUD_RST);
      active_q <= DATA_WIDTH'(BAUD_RST);
      irq_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      irq_q    <= irq_d;
    end
  end

  assign regs_o = regs_q;
  assign rate_o = active_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/uart_cfg_regbank.sv
// Multi-channel UART config register bank: write decode, OOB detection, dual read muxes and read pipes.
module uart_cfg_regbank
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned N_CH         = 3,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned BAUD_RST     = BAUD_RST_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_cfg_regbank_if.slave            bus,
  input  logic [N_CH-1:0]              uart_busy,
  input  logic [N_CH-1:0]              uart_error,
  input  logic [N_CH-1:0]              update_ok,
  output logic [N_CH-1:0]              uart_enable,
  output logic [3*N_CH-1:0]            uart_mode,
  output logic [DATA_WIDTH*N_CH-1:0]   uart_rate,
  output logic [N_CH-1:0]              irq
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned AW  = $clog2(N_CH) + 2;
  localparam int unsigned CHW = (AW > 2) ? AW - 2 : 1;

  ch_regs_t      regs [N_CH];
  logic [DW-1:0] rate [N_CH];

  logic [CHW-1:0] wr_ch;
  reg_e           wr_reg;
  logic           wr_oob;
  logic           wr_err_q;

  assign wr_ch  = CHW'(bus.wr_addr >> 2);
  assign wr_reg = reg_e'(bus.wr_addr[1:0]);
  assign wr_oob = 32'(wr_ch) >= N_CH;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic ch_wr;
    assign ch_wr = bus.wr_en && !wr_oob && (wr_ch == CHW'(c));

    uart_cfg_channel #(
      .DATA_WIDTH (DW),
      .BAUD_RST   (BAUD_RST)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (ch_wr),
      .wr_reg_i    (wr_reg),
      .wr_data_i   (bus.wr_data),
      .busy_i      (uart_busy[c]),
      .error_i     (uart_error[c]),
      .update_ok_i (update_ok[c]),
      .regs_o      (regs[c]),
      .rate_o      (rate[c]),
      .irq_o       (irq[c])
    );

    assign uart_enable[c]       = regs[c].ctrl[CTRL_EN];
    assign uart_mode[3*c +: 3]  = regs[c].ctrl[3:1];
    assign uart_rate[DW*c +: DW] = rate[c];
  end

  // OOB write flag, one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= bus.wr_en && wr_oob;
  end

  assign bus.wr_err = wr_err_q;

  logic           rd_en   [2];
  logic [AW-1:0]  rd_addr [2];
  logic [CHW-1:0] rd_ch   [2];
  logic [DW-1:0]  rd_word [2];

  assign rd_en[0]   = bus.rd_en_a;
  assign rd_en[1]   = bus.rd_en_b;
  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;
  assign rd_ch[0]   = CHW'(bus.rd_addr_a >> 2);
  assign rd_ch[1]   = CHW'(bus.rd_addr_b >> 2);

  // Read muxes; OOB channels and unimplemented bits read as zero
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (32'(rd_ch[p]) < N_CH) begin
        case (reg_e'(rd_addr[p][1:0]))
          REG_CTRL:   rd_word[p] = DW'(regs[rd_ch[p]].ctrl);
          REG_BAUD:   rd_word[p] = rate[rd_ch[p]];
          REG_STATUS: rd_word[p] = DW'(status_bits(regs[rd_ch[p]], uart_busy[rd_ch[p]]));
          REG_IRQ_EN: rd_word[p] = DW'({regs[rd_ch[p]].irq_en, 1'b0});
          default:    rd_word[p] = '0;
        endcase
      end
    end
  end

  logic [DW-1:0] pipe_data_q [2][READ_LATENCY];
  logic          pipe_vld_q  [2][READ_LATENCY];

  // Read delay pipes; reset flushes reads in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < READ_LATENCY; s++) begin
          pipe_vld_q[p][s]  <= 1'b0;
          pipe_data_q[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        pipe_vld_q[p][0] <= rd_en[p];
        if (rd_en[p]) pipe_data_q[p][0] <= rd_word[p];
        for (int s = 1; s < READ_LATENCY; s++) begin
          pipe_vld_q[p][s]  <= pipe_vld_q[p][s-1];
          pipe_data_q[p][s] <= pipe_data_q[p][s-1];
        end
      end
    end
  end

  assign bus.rd_data_a  = pipe_data_q[0][READ_LATENCY-1];
  assign bus.rd_valid_a = pipe_vld_q[0][READ_LATENCY-1];
  assign bus.rd_data_b  = pipe_data_q[1][READ_LATENCY-1];
  assign bus.rd_valid_b = pipe_vld_q[1][READ_LATENCY-1];

endmodule

// File: tb/tb_uart_cfg_regbank.sv
// Directed self-checking bench: RL=1 instance for register behaviour, RL=2 instance for read pipelining.
module tb_uart_cfg_regbank;

  localparam int unsigned DW  = 16;
  localparam int unsigned NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cfg_regbank_if #(.DATA_WIDTH(DW), .N_CH(NCH)) bus1 ();
  uart_cfg_regbank_if #(.DATA_WIDTH(DW), .N_CH(NCH)) bus2 ();

  logic [NCH-1:0]     busy, err_ev, upd;
  logic [NCH-1:0]     en1, irq1, en2, irq2;
  logic [3*NCH-1:0]   mode1, mode2;
  logic [DW*NCH-1:0]  rate1, rate2;
  logic [NCH-1:0]     zero_in;

  assign zero_in = '0;

  uart_cfg_regbank #(.DATA_WIDTH(DW), .N_CH(NCH), .READ_LATENCY(1), .BAUD_RST(9600)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus1),
    .uart_busy   (busy),
    .uart_error  (err_ev),
    .update_ok   (upd),
    .uart_enable (en1),
    .uart_mode   (mode1),
    .uart_rate   (rate1),
    .irq         (irq1)
  );

  uart_cfg_regbank #(.DATA_WIDTH(DW), .N_CH(NCH), .READ_LATENCY(2), .BAUD_RST(9600)) u_dut2 (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus2),
    .uart_busy   (zero_in),
    .uart_error  (zero_in),
    .update_ok   (zero_in),
    .uart_enable (en2),
    .uart_mode   (mode2),
    .uart_rate   (rate2),
    .irq         (irq2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [3:0] addr, input logic [DW-1:0] data);
    bus1.wr_en   = 1'b1;
    bus1.wr_addr = addr;
    bus1.wr_data = data;
    tick();
    bus1.wr_en   = 1'b0;
  endtask

  task automatic rda(input string tag, input logic [3:0] addr, input logic [DW-1:0] exp);
    bus1.rd_en_a   = 1'b1;
    bus1.rd_addr_a = addr;
    tick();
    bus1.rd_en_a   = 1'b0;
    check({tag, "_va"}, 32'(bus1.rd_valid_a), 32'd1);
    check(tag, 32'(bus1.rd_data_a), 32'(exp));
  endtask

  initial begin
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus1.rd_en_a = 1'b0; bus1.rd_addr_a = '0; bus1.rd_en_b = 1'b0; bus1.rd_addr_b = '0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.rd_en_a = 1'b0; bus2.rd_addr_a = '0; bus2.rd_en_b = 1'b0; bus2.rd_addr_b = '0;
    busy = '0; err_ev = '0; upd = '0;

    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid_a", 32'(bus1.rd_valid_a), 32'd0);
    check("rst_valid_b", 32'(bus1.rd_valid_b), 32'd0);
    check("rst_rdata_a", 32'(bus1.rd_data_a), 32'd0);
    check("rst_wr_err",  32'(bus1.wr_err), 32'd0);
    check("rst_irq",     32'(irq1), 32'd0);
    check("rst_enable",  32'(en1), 32'd0);
    check("rst_mode",    32'(mode1), 32'd0);
    check("rst_rate0",   32'(rate1[15:0]), 32'd9600);
    check("rst_rate1",   32'(rate1[31:16]), 32'd9600);
    check("rst_rate2",   32'(rate1[47:32]), 32'd9600);

    // Reset register values
    rda("rst_ctrl0",   4'd0, 16'd0);
    check("valid_drop", 32'(bus1.rd_valid_a), 32'd1);
    tick();
    check("valid_1cyc", 32'(bus1.rd_valid_a), 32'd0);
    rda("rst_baud0",   4'd1, 16'd9600);
    rda("rst_status0", 4'd2, 16'd0);
    rda("rst_irqen0",  4'd3, 16'd0);
    rda("rst_baud1",   4'd5, 16'd9600);

    // Shadowed BAUD write and commit on ch1
    wr1(4'd5, 16'd4800);
    check("baud_no_commit_rate", 32'(rate1[31:16]), 32'd9600);
    rda("baud1_active_old", 4'd5, 16'd9600);
    rda("status1_pending",  4'd6, 16'd4);
    upd[1] = 1'b1;
    tick();
    upd[1] = 1'b0;
    check("commit_rate1", 32'(rate1[31:16]), 32'd4800);
    rda("baud1_committed",  4'd5, 16'd4800);
    rda("status1_clear",    4'd6, 16'd0);

    // update_ok with nothing pending is ignored
    upd[0] = 1'b1;
    tick();
    upd[0] = 1'b0;
    check("commit_idle_rate0", 32'(rate1[15:0]), 32'd9600);

    // Busy write rejection on ch0 and cfg_err W1C
    busy[0] = 1'b1;
    wr1(4'd1, 16'd1200);
    rda("status0_rejected", 4'd2, 16'h9);
    rda("baud0_unchanged",  4'd1, 16'd9600);
    wr1(4'd2, 16'h8);
    rda("status0_w1c",      4'd2, 16'h1);
    busy[0] = 1'b0;

    // Sticky error, IRQ enable, registered irq
    err_ev[2] = 1'b1;
    tick();
    err_ev[2] = 1'b0;
    check("irq_masked", 32'(irq1), 32'd0);
    wr1(4'd11, 16'd2);
    check("irq_lag", 32'(irq1), 32'd0);
    tick();
    check("irq2_set", 32'(irq1), 32'b100);
    rda("status2_err", 4'd10, 16'd2);
    err_ev[2] = 1'b1;
    wr1(4'd10, 16'd2);
    err_ev[2] = 1'b0;
    rda("status2_set_wins", 4'd10, 16'd2);
    wr1(4'd10, 16'd2);
    rda("status2_cleared", 4'd10, 16'd0);
    check("irq2_clear", 32'(irq1), 32'd0);

    // CTRL / IRQ_EN masking and config outputs on ch1
    wr1(4'd4, 16'hFFFF);
    check("en1_set",   32'(en1), 32'b010);
    check("mode1_set", 32'(mode1[5:3]), 32'd7);
    rda("ctrl1_mask",  4'd4, 16'hF);
    wr1(4'd7, 16'hFFFF);
    rda("irqen1_mask", 4'd7, 16'hE);

    // OOB write and read
    wr1(4'd12, 16'h1234);
    check("oob_wr_err", 32'(bus1.wr_err), 32'd1);
    tick();
    check("oob_wr_err_pulse", 32'(bus1.wr_err), 32'd0);
    check("oob_rate_kept", 32'(rate1[15:0]), 32'd9600);
    rda("oob_no_alias_ctrl0", 4'd0, 16'd0);
    bus1.rd_en_b = 1'b1; bus1.rd_addr_b = 4'd13;
    tick();
    bus1.rd_en_b = 1'b0;
    check("oob_rd_valid_b", 32'(bus1.rd_valid_b), 32'd1);
    check("oob_rd_data_b",  32'(bus1.rd_data_b), 32'd0);

    // Same-cycle read and write of one address returns the old value
    bus1.rd_en_a = 1'b1; bus1.rd_addr_a = 4'd0;
    wr1(4'd0, 16'd5);
    bus1.rd_en_a = 1'b0;
    check("rw_same_old", 32'(bus1.rd_data_a), 32'd0);
    check("en0_set",     32'(en1), 32'b011);
    check("mode0_set",   32'(mode1[2:0]), 32'd2);
    rda("rw_same_new", 4'd0, 16'd5);

    // Same-cycle commit and BAUD write on ch2
    wr1(4'd9, 16'd100);
    upd[2] = 1'b1;
    wr1(4'd9, 16'd200);
    upd[2] = 1'b0;
    check("commit_old_shadow", 32'(rate1[47:32]), 32'd100);
    rda("pending_stays", 4'd10, 16'd4);
    upd[2] = 1'b1;
    tick();
    upd[2] = 1'b0;
    check("commit_new_shadow", 32'(rate1[47:32]), 32'd200);

    // Independent simultaneous reads on A and B
    bus1.rd_en_a = 1'b1; bus1.rd_addr_a = 4'd5;
    bus1.rd_en_b = 1'b1; bus1.rd_addr_b = 4'd9;
    tick();
    bus1.rd_en_a = 1'b0; bus1.rd_en_b = 1'b0;
    check("dual_a", 32'(bus1.rd_data_a), 32'd4800);
    check("dual_b", 32'(bus1.rd_data_b), 32'd200);

    // RL=2 instance: back-to-back reads on both ports
    bus2.wr_en = 1'b1; bus2.wr_addr = 4'd0; bus2.wr_data = 16'd3;
    tick();
    bus2.wr_en = 1'b0;
    begin
      logic [DW-1:0] exp_a [3];
      logic [DW-1:0] exp_b [3];
      exp_a[0] = 16'd3; exp_a[1] = 16'd9600; exp_a[2] = 16'd0;
      exp_b[0] = 16'd0; exp_b[1] = 16'd9600; exp_b[2] = 16'd3;
      for (int i = 0; i < 5; i++) begin
        bus2.rd_en_a = (i < 3);
        bus2.rd_en_b = (i < 3);
        if (i < 3) begin
          bus2.rd_addr_a = 4'(i);
          bus2.rd_addr_b = 4'(2 - i);
        end
        tick();
        if (i >= 1 && i <= 3) begin
          check($sformatf("rl2_va_%0d", i), 32'(bus2.rd_valid_a), 32'd1);
          check($sformatf("rl2_da_%0d", i), 32'(bus2.rd_data_a), 32'(exp_a[i-1]));
          check($sformatf("rl2_vb_%0d", i), 32'(bus2.rd_valid_b), 32'd1);
          check($sformatf("rl2_db_%0d", i), 32'(bus2.rd_data_b), 32'(exp_b[i-1]));
        end else begin
          check($sformatf("rl2_va_idle_%0d", i), 32'(bus2.rd_valid_a), 32'd0);
          check($sformatf("rl2_vb_idle_%0d", i), 32'(bus2.rd_valid_b), 32'd0);
        end
      end
    end

    // RL=2: reset while a read is in flight drops it
    bus2.rd_en_a = 1'b1; bus2.rd_addr_a = 4'd1;
    tick();
    bus2.rd_en_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rl2_rst_drop0", 32'(bus2.rd_valid_a), 32'd0);
    tick();
    check("rl2_rst_drop1", 32'(bus2.rd_valid_a), 32'd0);
    check("rl2_rst_data",  32'(bus2.rd_data_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
